pim_weight_loader: RTL and testbench

- Write-side counterpart of the bit-sliced PIM vector-matrix datapath.
- Accepts a byte stream of weights over valid/ready and packs INPUT_SIZE weights into one row.
- Programs each packed row into the PIM macro weight array through an address/data/ack write handshake.
- Sequences rows from a base address, then signals completion so the compute path can assert its compute enable.

---
 rtl/pim_pkg.sv | 17 +
 rtl/pim_weight_loader_if.sv | 27 ++
 rtl/pim_row_packer.sv | 38 +++
 rtl/pim_weight_loader.sv | 134 +++++++++++++
 tb/tb_pim_weight_loader.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_pkg.sv
// rtl/pim_pkg.sv - shared types and default sizes for the PIM weight loader
package pim_pkg;

    localparam int INPUT_SIZE = 32;
    localparam int WEIGHT_W   = 8;
    localparam int ADDR_W     = 5;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FIN
    } state_t;

    typedef logic [INPUT_SIZE*WEIGHT_W-1:0] row_t;

endpackage

// File: rtl/pim_weight_loader_if.sv
// rtl/pim_weight_loader_if.sv - weight byte stream and macro row-write handshake
interface pim_weight_loader_if #(
    parameter int INPUT_SIZE = pim_pkg::INPUT_SIZE,
    parameter int WEIGHT_W   = pim_pkg::WEIGHT_W,
    parameter int ADDR_W     = pim_pkg::ADDR_W
);

    logic                           s_valid;
    logic                           s_ready;
    logic [WEIGHT_W-1:0]            s_data;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_addr;
    logic [INPUT_SIZE*WEIGHT_W-1:0] wr_data;
    logic                           wr_ack;

    // master is the loader; slave is the byte source plus the macro
    modport master (
        input  s_valid, s_data, wr_ack,
        output s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output s_valid, s_data, wr_ack,
        input  s_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/pim_row_packer.sv
// rtl/pim_row_packer.sv - packs accepted weight bytes into one row, lane 0 first
module pim_row_packer #(
    parameter int INPUT_SIZE = pim_pkg::INPUT_SIZE,
    parameter int WEIGHT_W   = pim_pkg::WEIGHT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_fill,
    input  logic                           i_valid,
    input  logic [WEIGHT_W-1:0]            i_data,
    output logic                           o_ready,
    output logic                           o_last,
    output logic [INPUT_SIZE*WEIGHT_W-1:0] o_row
);

    localparam int LANE_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

    logic [LANE_W-1:0]              r_lane;
    logic [INPUT_SIZE*WEIGHT_W-1:0] r_row;
    logic                           w_accept;

    assign o_ready  = i_fill;
    assign w_accept = i_fill && i_valid;
    assign o_last   = w_accept && (r_lane == LANE_W'(INPUT_SIZE - 1));
    assign o_row    = r_row;

    // the row register doubles as the held write data, so it only changes on accepts
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane <= '0;
            r_row  <= '0;
        end else if (w_accept) begin
            r_row[r_lane*WEIGHT_W +: WEIGHT_W] <= i_data;
            r_lane <= o_last ? '0 : r_lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/pim_weight_loader.sv
// rtl/pim_weight_loader.sv - streams weight rows into the PIM macro array
// Optional write-ack timeout enabled by defining WR_TIMEOUT_EN.
module pim_weight_loader #(
    parameter int INPUT_SIZE = pim_pkg::INPUT_SIZE,
    parameter int WEIGHT_W   = pim_pkg::WEIGHT_W,
    parameter int ADDR_W     = pim_pkg::ADDR_W,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_rows,
    output logic              busy,
    output logic              done,
    output logic              err,
    pim_weight_loader_if.master bus
);

    import pim_pkg::*;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_rows;
    logic                w_fill;
    logic                w_wr_en;
    logic                w_busy;
    logic                w_done;
    logic                w_last;
    logic                w_start_ok;
    logic                w_ack_ok;
    logic                w_tmo_hit;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_ack_ok   = (r_state == WRITE) && bus.wr_ack;

    pim_row_packer #(
        .INPUT_SIZE (INPUT_SIZE),
        .WEIGHT_W   (WEIGHT_W)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .i_fill  (w_fill),
        .i_valid (bus.s_valid),
        .i_data  (bus.s_data),
        .o_ready (bus.s_ready),
        .o_last  (w_last),
        .o_row   (bus.wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next = (num_rows == '0) ? FIN : FILL;
            end
            FILL: begin
                if (w_last) w_next = WRITE;
            end
            WRITE: begin
                // an ack on the final timeout cycle still counts as acceptance
                if (bus.wr_ack)     w_next = (r_rows == {{ADDR_W{1'b0}}, 1'b1}) ? FIN : FILL;
                else if (w_tmo_hit) w_next = FIN;
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_fill  = 1'b0;
        w_wr_en = 1'b0;
        w_busy  = 1'b1;
        w_done  = 1'b0;
        case (r_state)
            IDLE:    w_busy  = 1'b0;
            FILL:    w_fill  = 1'b1;
            WRITE:   w_wr_en = 1'b1;
            FIN:     w_done  = 1'b1;
            default: w_busy  = 1'b0;
        endcase
    end

    assign bus.wr_en   = w_wr_en;
    assign bus.wr_addr = r_addr;
    assign busy        = w_busy;
    assign done        = w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_rows <= '0;
        end else if (w_start_ok) begin
            r_addr <= base_addr;
            r_rows <= num_rows;
        end else if (w_ack_ok) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_rows <= r_rows - {{ADDR_W{1'b0}}, 1'b1};
        end
    end

`ifdef WR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // held at zero outside WRITE so every entry starts a fresh wait
    always_ff @(posedge clk) begin
        if (reset || (r_state != WRITE)) r_tmo <= '0;
        else                             r_tmo <= r_tmo + TMO_W'(1);
    end

    assign w_tmo_hit = (r_state == WRITE) && !bus.wr_ack && (r_tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset)          r_err <= 1'b0;
        else if (w_start_ok) r_err <= 1'b0;
        else if (w_tmo_hit)  r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pim_weight_loader.sv
// tb/tb_pim_weight_loader.sv - directed self-checking bench for pim_weight_loader
module tb_pim_weight_loader;

    import pim_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] base_addr;
    logic [5:0] num_rows;
    logic       busy;
    logic       done;
    logic       err;

    pim_weight_loader_if ifc ();

    pim_weight_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic row_t make_row(input logic [7:0] first);
        row_t r;
        for (int k = 0; k < INPUT_SIZE; k++) r[k*8 +: 8] = first + 8'(k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ack_delay = 0;
    bit ack_never = 1'b0;
    int wcnt      = 0;

    initial begin
        ifc.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.wr_en) begin
                ifc.wr_ack = !ack_never && (wcnt >= ack_delay);
                wcnt++;
            end else begin
                ifc.wr_ack = 1'b0;
                wcnt       = 0;
            end
        end
    end

    logic [4:0] wq_addr[$];
    row_t       wq_data[$];
    int         en_cycles  = 0;
    int         rdy_cycles = 0;
    int         done_cnt   = 0;
    bit         p_wait     = 1'b0;
    logic [4:0] p_addr;
    row_t       p_data;

    // negedge view of the write port: records accepted rows and checks hold during waits
    initial begin
        forever begin
            @(negedge clk);
            if (ifc.wr_en) begin
                en_cycles++;
                check("sready_in_write", ifc.s_ready, 0);
                if (p_wait) begin
                    check("hold_addr", ifc.wr_addr, p_addr);
                    check("hold_data", ifc.wr_data, p_data);
                end
                if (ifc.wr_ack) begin
                    wq_addr.push_back(ifc.wr_addr);
                    wq_data.push_back(ifc.wr_data);
                    p_wait = 1'b0;
                end else begin
                    p_wait = 1'b1;
                    p_addr = ifc.wr_addr;
                    p_data = ifc.wr_data;
                end
            end else begin
                p_wait = 1'b0;
            end
            if (ifc.s_ready) rdy_cycles++;
            if (done) done_cnt++;
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        en_cycles  = 0;
        rdy_cycles = 0;
        done_cnt   = 0;
    endtask

    task automatic start_job(input logic [4:0] b, input logic [5:0] n);
        base_addr = b;
        num_rows  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] first, input int count, input bit gap);
        int t;
        for (int i = 0; i < count; i++) begin
            ifc.s_valid = 1'b1;
            ifc.s_data  = first + 8'(i);
            t = 0;
            @(negedge clk);
            while (!ifc.s_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                check("sready_timeout", 0, 1);
                ifc.s_valid = 1'b0;
                return;
            end
            tick();
            if (gap) begin
                ifc.s_valid = 1'b0;
                tick();
            end
        end
        ifc.s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic check_write(input int idx, input logic [4:0] a, input row_t d);
        if (idx < wq_addr.size()) begin
            check("wr_addr_seq", wq_addr[idx], a);
            check("wr_data_seq", wq_data[idx], d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        num_rows    = '0;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        repeat (3) tick();
        check("rst_s_ready", ifc.s_ready, 0);
        check("rst_wr_en",   ifc.wr_en,   0);
        check("rst_busy",    busy,        0);
        check("rst_done",    done,        0);
        check("rst_err",     err,         0);
        check("rst_wr_addr", ifc.wr_addr, 0);
        check("rst_wr_data", ifc.wr_data, 0);
        reset = 1'b0;
        tick();

        // single row, immediate ack
        clear_log();
        ack_delay = 0;
        start_job(5'd3, 6'd1);
        check("t1_busy",    busy,        1);
        check("t1_s_ready", ifc.s_ready, 1);
        send_bytes(8'h00, 32, 1'b0);
        check("t1_wr_en",   ifc.wr_en,   1);
        check("t1_wr_addr", ifc.wr_addr, 3);
        check("t1_wr_data", ifc.wr_data, make_row(8'h00));
        tick();
        check("t1_wr_en_drop", ifc.wr_en, 0);
        check("t1_done",       done,      1);
        tick();
        check("t1_done_drop", done, 0);
        check("t1_idle",      busy, 0);
        check("t1_writes",    wq_addr.size(), 1);
        check("t1_en_cycles", en_cycles, 1);

        // wrap and back-pressure
        clear_log();
        ack_delay = 4;
        start_job(5'd30, 6'd3);
        send_bytes(8'h40, 96, 1'b0);
        wait_done();
        tick();
        check("t2_idle",      busy, 0);
        check("t2_writes",    wq_addr.size(), 3);
        check_write(0, 5'd30, make_row(8'h40));
        check_write(1, 5'd31, make_row(8'h60));
        check_write(2, 5'd0,  make_row(8'h80));
        check("t2_en_cycles", en_cycles, 15);
        check("t2_wr_data_kept", ifc.wr_data, make_row(8'h80));

        // zero rows
        clear_log();
        ack_delay = 0;
        start_job(5'd5, 6'd0);
        check("t3_done",    done,        1);
        check("t3_s_ready", ifc.s_ready, 0);
        check("t3_busy",    busy,        1);
        tick();
        check("t3_done_drop", done, 0);
        check("t3_idle",      busy, 0);
        check("t3_en_cycles", en_cycles,  0);
        check("t3_rdy",       rdy_cycles, 0);
        check("t3_done_cnt",  done_cnt,   1);
        check("t3_wr_addr",   ifc.wr_addr, 5);

        // stream gaps and start ignored while busy
        clear_log();
        start_job(5'd10, 6'd2);
        send_bytes(8'h80, 5, 1'b1);
        base_addr = 5'd20;
        num_rows  = 6'd1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("t4_addr_kept", ifc.wr_addr, 10);
        send_bytes(8'h85, 59, 1'b1);
        wait_done();
        tick();
        check("t4_writes",   wq_addr.size(), 2);
        check_write(0, 5'd10, make_row(8'h80));
        check_write(1, 5'd11, make_row(8'hA0));
        check("t4_done_cnt", done_cnt, 1);

        // reset mid-job
        clear_log();
        start_job(5'd7, 6'd2);
        send_bytes(8'h11, 10, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_s_ready", ifc.s_ready, 0);
        check("t5_wr_en",   ifc.wr_en,   0);
        check("t5_busy",    busy,        0);
        check("t5_done",    done,        0);
        check("t5_err",     err,         0);
        check("t5_wr_addr", ifc.wr_addr, 0);
        check("t5_wr_data", ifc.wr_data, 0);
        check("t5_writes",  wq_addr.size(), 0);
        clear_log();
        start_job(5'd0, 6'd1);
        send_bytes(8'hC0, 32, 1'b0);
        wait_done();
        tick();
        check("t5_writes_new", wq_addr.size(), 1);
        check_write(0, 5'd0, make_row(8'hC0));

`ifdef WR_TIMEOUT_EN
        // write-ack timeout
        clear_log();
        ack_never = 1'b1;
        start_job(5'd2, 6'd2);
        send_bytes(8'h20, 32, 1'b0);
        wait_done();
        check("t6_err", err, 1);
        tick();
        check("t6_idle",      busy, 0);
        check("t6_en_cycles", en_cycles, 16);
        check("t6_writes",    wq_addr.size(), 0);
        check("t6_done_cnt",  done_cnt, 1);
        check("t6_err_held",  err, 1);
        ack_never = 1'b0;
        start_job(5'd0, 6'd0);
        check("t6_err_clear", err, 0);
        tick();
`else
        check("err_tied", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
